program_loader: RTL and testbench
=================================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter rom_size, default 22, meaning ROM depth in 16-bit words.
REQ-002 Parameter ram_size, default 32, meaning RAM depth in 16-bit words.
REQ-003 Derived widths: RA = $clog2(rom_size), MA = $clog2(ram_size).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset; asserted (0) forces reset state immediately, released synchronously to clk by the environment.
REQ-006 in_valid  input  1  upstream word valid.
REQ-007 in_data  input  16  upstream word (header or payload).
REQ-008 in_ready  output  1  loader accepts in_data this cycle; handshake = in_valid & in_ready at a rising edge.
REQ-009 rom_we  output  1  one-cycle ROM write strobe.
REQ-010 rom_addr  output  RA  ROM write address.
REQ-011 rom_wdata  output  16  ROM write data.
REQ-012 ram_we  output  1  one-cycle RAM write strobe.
REQ-013 ram_addr  output  MA  RAM write address.
REQ-014 ram_wdata  output  16  RAM write data.
REQ-015 cpu_ended  input  1  computer's ended flag.
REQ-016 cpu_reset  output  1  active-high reset driven to the downstream computer.
REQ-017 done  output  1  computer ran and reported ended.
REQ-018 error  output  1  sticky malformed-header flag.

Function
REQ-019 States: HEADER, DATA, RUN, DONE, ERROR; reset state HEADER.
REQ-020 Header word: bit15 = target (0 ROM, 1 RAM), bit14 reserved, bits[13:0] = count N.
REQ-021 HEADER: in_ready=1; on handshake with N=0 -> RUN; N>0 and N<=depth of target -> DATA, latch target and N, clear address counter to 0; N>depth or bit14=1 -> ERROR.
REQ-022 DATA: in_ready=1; each handshake registers rom/ram addr=counter, wdata=in_data, and pulses the target's we for exactly the next cycle; counter increments by 1.
REQ-023 DATA: handshake of the N-th word -> HEADER; counter never exceeds N-1, so address wrap cannot occur.
REQ-024 Write latency: we/addr/wdata appear one cycle after the accepting edge; back-to-back handshakes give back-to-back strobes.
REQ-025 Only one of rom_we/ram_we high in any cycle; non-target strobe stays 0.
REQ-026 addr/wdata hold last written value when we=0.
REQ-027 cpu_reset=1 in HEADER, DATA, ERROR; 0 in RUN and DONE, switching on the cycle after the state is entered.
REQ-028 RUN: in_ready=0; cpu_ended sampled 1 -> DONE; cpu_ended ignored in all other states.
REQ-029 DONE: done=1, in_ready=1; a header handshake reasserts cpu_reset, clears done, and is processed as in REQ-021 (reload without global reset).
REQ-030 ERROR: error=1, in_ready=0, all we=0; exit only via reset.
REQ-031 in_data changes while in_valid=1 and in_ready=0 have no effect.

Reset
REQ-032 While reset=0: state HEADER, in_ready=0, rom_we=0, ram_we=0, rom_addr=0, ram_addr=0, rom_wdata=0, ram_wdata=0, cpu_reset=1, done=0, error=0, counter=0.
REQ-033 in_ready rises to 1 the first cycle after reset release.
REQ-034 Reset mid-DATA aborts the frame; words already written are not undone, no further strobe is issued.

Verification
REQ-035 ROM frame 0x0003, words 0x0001,0x0002,0x0003 back-to-back -> rom_we pulses 3 consecutive cycles at addr 0,1,2 with matching data; ram_we stays 0.
REQ-036 RAM frame 0x8002, words 13, 8, then header 0x0000 -> ram[0]=13, ram[1]=8, cpu_reset drops 1 cycle after run header; cpu_ended=1 -> done=1 next cycle.
REQ-037 Header 0x0017 (23 > rom_size 22) -> error=1, in_ready=0, cpu_reset=1, no strobes until reset; header 0x0016 accepted.
REQ-038 in_valid toggled every other cycle in DATA with N=4 -> exactly 4 strobes, addresses 0..3, no gaps skipped or duplicated.
REQ-039 reset=0 asserted after 2 of 5 words -> outputs match REQ-032 immediately; next header restarts at address 0.
REQ-040 From DONE, send 0x8001, 0x0005, 0x0000 -> cpu_reset=1 during reload, ram[0]=5, cpu_reset=0 again, done=0 until cpu_ended.

Source files
------------

// File: rtl/program_loader_if.sv
// Bundles the loader's upstream word stream, the ROM/RAM write ports and the
// control/status lines to the downstream computer.
// The environment drives the master side and the loader drives the slave side.
interface program_loader_if #(
  parameter int rom_size = 22,
  parameter int ram_size = 32
);
  localparam int RA = $clog2(rom_size);
  localparam int MA = $clog2(ram_size);

  // Upstream word stream
  logic          in_valid;
  logic [15:0]   in_data;
  logic          in_ready;

  // ROM write port
  logic          rom_we;
  logic [RA-1:0] rom_addr;
  logic [15:0]   rom_wdata;

  // RAM write port
  logic          ram_we;
  logic [MA-1:0] ram_addr;
  logic [15:0]   ram_wdata;

  // Downstream computer control and loader status
  logic          cpu_ended;
  logic          cpu_reset;
  logic          done;
  logic          error;

  modport master (
    output in_valid, in_data, cpu_ended,
    input  in_ready, rom_we, rom_addr, rom_wdata,
           ram_we, ram_addr, ram_wdata, cpu_reset, done, error
  );

  modport slave (
    input  in_valid, in_data, cpu_ended,
    output in_ready, rom_we, rom_addr, rom_wdata,
           ram_we, ram_addr, ram_wdata, cpu_reset, done, error
  );
endinterface

// File: rtl/program_loader.sv
// Program loader: takes header-framed word streams and writes the payload
// into ROM or RAM. It holds the downstream computer in reset while loading,
// releases it on a zero-count header and reports when the computer has ended.
// A malformed header locks the loader in ERROR until the next reset.
module program_loader #(
  parameter int rom_size = 22,
  parameter int ram_size = 32
) (
  input  logic             clk,
  input  logic             reset,
  program_loader_if.slave  bus
);
  localparam int RA = $clog2(rom_size);
  localparam int MA = $clog2(ram_size);
  localparam logic [13:0] ROM_DEPTH = 14'(rom_size);
  localparam logic [13:0] RAM_DEPTH = 14'(ram_size);

  typedef enum logic [2:0] {
    HEADER,
    DATA,
    RUN,
    DONE,
    ERROR
  } state_t;

  state_t        state, next_state;

  // Frame context latched from the header
  logic          target_q;      // 0 = ROM, 1 = RAM
  logic [13:0]   count_q;       // payload words in this frame
  logic [13:0]   counter_q;     // index of the next payload word

  // Registered outputs
  logic          in_ready_q;
  logic          cpu_reset_q;
  logic          rom_we_q, ram_we_q;
  logic [RA-1:0] rom_addr_q;
  logic [MA-1:0] ram_addr_q;
  logic [15:0]   rom_wdata_q, ram_wdata_q;

  // Decoded controls
  logic          accept;
  logic          load_hdr;
  logic          write_word;
  logic          last_word;
  logic          hdr_target, hdr_rsvd, hdr_fits;
  logic [13:0]   hdr_count;

  assign accept     = bus.in_valid & in_ready_q;
  assign hdr_target = bus.in_data[15];
  assign hdr_rsvd   = bus.in_data[14];
  assign hdr_count  = bus.in_data[13:0];
  assign hdr_fits   = hdr_target ? (hdr_count <= RAM_DEPTH) : (hdr_count <= ROM_DEPTH);

  // Next-state and per-cycle control decode
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
    next_state = state;
    load_hdr   = 1'b0;
    write_word = 1'b0;
    last_word  = 1'b0;
    case (state)
      HEADER, DONE: begin
        if (accept) begin
          if (hdr_rsvd || !hdr_fits) begin
            next_state = ERROR;
          end else if (hdr_count == 14'd0) begin
            next_state = RUN;
          end else begin
            next_state = DATA;
            load_hdr   = 1'b1;
          end
        end
      end
      DATA: begin
        if (accept) begin
          write_word = 1'b1;
          if (counter_q == count_q - 14'd1) begin
            last_word  = 1'b1;
            next_state = HEADER;
          end
        end
      end
      RUN: begin
        if (bus.cpu_ended) next_state = RUN == state ? DONE : state;
      end
      ERROR: next_state = ERROR;
      default: next_state = HEADER;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset) state <= HEADER;
    else        state <= next_state;
  end

  // Frame context, write ports and registered control outputs
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: every register here is reset, including addresses and data, because their reset values are visible outputs.
    if (!reset) begin
      target_q    <= 1'b0;
      count_q     <= '0;
      counter_q   <= '0;
      in_ready_q  <= 1'b0;
      cpu_reset_q <= 1'b1;
      rom_we_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      rom_addr_q  <= '0;
      ram_addr_q  <= '0;
      rom_wdata_q <= '0;
      ram_wdata_q <= '0;
    end else begin
      // Ready follows the state being entered, so it is low through reset and in RUN/ERROR.
      in_ready_q  <= (next_state == HEADER) || (next_state == DATA) || (next_state == DONE);
      // The computer reset follows the current state, one cycle behind the transition.
      cpu_reset_q <= !((state == RUN) || (state == DONE));
      rom_we_q    <= write_word & ~target_q;
      ram_we_q    <= write_word & target_q;

      if (load_hdr) begin
        target_q  <= hdr_target;
        count_q   <= hdr_count;
        counter_q <= '0;
      end

      if (write_word) begin
        counter_q <= last_word ? 14'd0 : counter_q + 14'd1;
        if (target_q) begin
          ram_addr_q  <= counter_q[MA-1:0];
          ram_wdata_q <= bus.in_data;
        end else begin
          rom_addr_q  <= counter_q[RA-1:0];
          rom_wdata_q <= bus.in_data;
        end
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.cpu_reset = cpu_reset_q;
  assign bus.rom_we    = rom_we_q;
  assign bus.rom_addr  = rom_addr_q;
  assign bus.rom_wdata = rom_wdata_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign bus.done      = (state == DONE);
  assign bus.error     = (state == ERROR);
endmodule

// File: tb/tb_program_loader.sv
// Directed testbench for program_loader: frames into ROM and RAM, run/done
// handshake with the computer, reload from DONE, gapped input, reset abort,
// header error and depth boundaries.
module tb_program_loader;
  logic clk = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  program_loader_if #(.rom_size(22), .ram_size(32)) bus();

  program_loader #(.rom_size(22), .ram_size(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int both_we = 0;
  int rom_a[$], rom_d[$], rom_c[$];
  int ram_a[$], ram_d[$], ram_c[$];

  always @(posedge clk) cyc++;

  // Log every write strobe at the falling edge, where outputs are stable
  always @(negedge clk) begin
    if (bus.rom_we === 1'b1) begin
      rom_a.push_back(int'(bus.rom_addr));
      rom_d.push_back(int'(bus.rom_wdata));
      rom_c.push_back(cyc);
    end
    if (bus.ram_we === 1'b1) begin
      ram_a.push_back(int'(bus.ram_addr));
      ram_d.push_back(int'(bus.ram_wdata));
      ram_c.push_back(cyc);
    end
    if (bus.rom_we === 1'b1 && bus.ram_we === 1'b1) both_we++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the handshake
  task automatic send(input logic [15:0] w);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("send_timeout", 32'(n), 32'd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, rb, rs, qs;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.cpu_ended = 1'b0;

    // Reset state
    idle(3);
    check("rst_in_ready",  bus.in_ready,  1'b0);
    check("rst_rom_we",    bus.rom_we,    1'b0);
    check("rst_ram_we",    bus.ram_we,    1'b0);
    check("rst_rom_addr",  bus.rom_addr,  0);
    check("rst_ram_addr",  bus.ram_addr,  0);
    check("rst_rom_wdata", bus.rom_wdata, 0);
    check("rst_ram_wdata", bus.ram_wdata, 0);
    check("rst_cpu_reset", bus.cpu_reset, 1'b1);
    check("rst_done",      bus.done,      1'b0);
    check("rst_error",     bus.error,     1'b0);
    reset = 1'b1;
    check("rdy_at_release", bus.in_ready, 1'b0);
    @(negedge clk);
    check("rdy_after_release", bus.in_ready, 1'b1);

    // ROM frame of three back-to-back words
    send(16'h0003); send(16'h0001); send(16'h0002); send(16'h0003);
    idle(2);
    check("rom3_count", rom_a.size(), 3);
    for (int i = 0; i < 3; i++) begin
      check("rom3_addr", rom_a[i], i);
      check("rom3_data", rom_d[i], i + 1);
    end
    check("rom3_consecutive", rom_c[2] - rom_c[0], 2);
    check("rom3_no_ram", ram_a.size(), 0);
    check("rom_addr_hold",  bus.rom_addr,  2);
    check("rom_wdata_hold", bus.rom_wdata, 3);

    // cpu_ended has no effect outside RUN
    bus.cpu_ended = 1'b1;
    idle(2);
    check("ended_ignored_done", bus.done, 1'b0);
    check("hdr_cpu_reset", bus.cpu_reset, 1'b1);
    bus.cpu_ended = 1'b0;

    // RAM frame then run header
    send(16'h8002); send(16'd13); send(16'd8);
    send(16'h0000);
    check("run_entry_cpu_reset", bus.cpu_reset, 1'b1);
    check("run_in_ready", bus.in_ready, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h8001;
    @(negedge clk);
    check("run_cpu_reset_drop", bus.cpu_reset, 1'b0);
    bus.in_data = 16'h0005;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("run_ignores_data", ram_a.size(), 2);
    check("run_done_low", bus.done, 1'b0);
    check("ram0_addr", ram_a[0], 0);
    check("ram0_data", ram_d[0], 13);
    check("ram1_addr", ram_a[1], 1);
    check("ram1_data", ram_d[1], 8);
    check("ram_frame_no_rom", rom_a.size(), 3);
    bus.cpu_ended = 1'b1;
    @(negedge clk);
    bus.cpu_ended = 1'b0;
    check("done_set", bus.done, 1'b1);
    check("done_in_ready", bus.in_ready, 1'b1);
    @(negedge clk);
    check("done_hold", bus.done, 1'b1);
    check("done_cpu_reset", bus.cpu_reset, 1'b0);

    // Reload from DONE without a global reset
    send(16'h8001);
    check("reload_done_clr", bus.done, 1'b0);
    send(16'h0005);
    check("reload_cpu_reset", bus.cpu_reset, 1'b1);
    send(16'h0000);
    @(negedge clk);
    check("reload_cpu_reset_drop", bus.cpu_reset, 1'b0);
    check("reload_ram_count", ram_a.size(), 3);
    check("reload_ram_addr", ram_a[2], 0);
    check("reload_ram_data", ram_d[2], 5);
    idle(2);
    check("reload_done_wait", bus.done, 1'b0);
    bus.cpu_ended = 1'b1;
    @(negedge clk);
    bus.cpu_ended = 1'b0;
    check("reload_done_set", bus.done, 1'b1);

    // Gapped valid in a four-word ROM frame
    base = rom_a.size();
    send(16'h0004);
    for (int i = 0; i < 4; i++) begin
      send(16'h00A0 + 16'(i));
      bus.in_data = 16'hFFFF;
      @(negedge clk);
    end
    idle(2);
    check("gap_count", rom_a.size(), base + 4);
    for (int i = 0; i < 4; i++) begin
      check("gap_addr", rom_a[base + i], i);
      check("gap_data", rom_d[base + i], 32'h00A0 + 32'(i));
    end
    check("gap_spacing", rom_c[base + 1] - rom_c[base], 2);
    check("gap_back_header", bus.in_ready, 1'b1);

    // Reset in the middle of a five-word RAM frame
    rb = ram_a.size();
    send(16'h8005); send(16'h0011); send(16'h0022);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h0033;
    #2 reset = 1'b0;
    #1;
    check("abort_in_ready",  bus.in_ready,  1'b0);
    check("abort_ram_we",    bus.ram_we,    1'b0);
    check("abort_ram_addr",  bus.ram_addr,  0);
    check("abort_ram_wdata", bus.ram_wdata, 0);
    check("abort_rom_addr",  bus.rom_addr,  0);
    check("abort_cpu_reset", bus.cpu_reset, 1'b1);
    check("abort_done",      bus.done,      1'b0);
    idle(3);
    bus.in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("abort_no_more_strobes", ram_a.size(), rb + 2);
    check("abort_w0", ram_d[rb], 16'h0011);
    check("abort_w1", ram_d[rb + 1], 16'h0022);
    send(16'h8001); send(16'h0077);
    idle(1);
    check("restart_addr", ram_a[rb + 2], 0);
    check("restart_data", ram_d[rb + 2], 16'h0077);

    // Oversized header locks into ERROR
    rs = rom_a.size();
    qs = ram_a.size();
    send(16'h0017);
    check("err_flag", bus.error, 1'b1);
    check("err_in_ready", bus.in_ready, 1'b0);
    check("err_cpu_reset", bus.cpu_reset, 1'b1);
    bus.in_valid  = 1'b1;
    bus.in_data   = 16'h0001;
    bus.cpu_ended = 1'b1;
    idle(4);
    bus.in_valid  = 1'b0;
    bus.cpu_ended = 1'b0;
    check("err_sticky", bus.error, 1'b1);
    check("err_no_done", bus.done, 1'b0);
    check("err_no_rom", rom_a.size(), rs);
    check("err_no_ram", ram_a.size(), qs);
    reset = 1'b0;
    @(negedge clk);
    check("err_cleared", bus.error, 1'b0);
    reset = 1'b1;
    @(negedge clk);

    // Full-depth ROM frame is accepted
    send(16'h0016);
    check("hdr22_no_err", bus.error, 1'b0);
    check("hdr22_ready", bus.in_ready, 1'b1);
    for (int i = 0; i < 22; i++) send(16'h0100 + 16'(i));
    idle(1);
    check("full_count", rom_a.size(), rs + 22);
    check("full_first_addr", rom_a[rs], 0);
    check("full_last_addr", rom_a[rs + 21], 21);
    check("full_last_data", rom_d[rs + 21], 16'h0115);

    // Reserved header bit is an error
    send(16'h4001);
    check("rsvd_err", bus.error, 1'b1);

    check("one_hot_we", both_we, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
